// File: rtl/monster_rom_pkg.sv
// Shared constants and return-tag type for the monster sprite ROM arbiter.
package monster_rom_pkg;

  localparam int unsigned MONSTER_W     = 26;
  localparam int unsigned MONSTER_H     = 37;
  localparam int unsigned MONSTER_DEPTH = 962;
  localparam int unsigned ROM_ADDR_W    = 10;
  localparam int unsigned PIX_W         = 8;

  // One in-flight read: valid, originating port (0/1), address out of range.
  typedef struct packed {
    logic vld;
    logic port;
    logic oor;
  } rd_tag_t;

endpackage

// File: rtl/monster_rom_arbiter_rd_tag_pipe.sv
// RD_LAT-deep shift register carrying read tags alongside the ROM latency.
module rd_tag_pipe
  import monster_rom_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stage [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RD_LAT); i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < int'(RD_LAT); i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[RD_LAT-1];

endmodule

// File: rtl/monster_rom_arbiter.sv
// Two-port arbiter for the sprite ROM: renderer has priority, scanner has a
// starvation guard; read data returns tagged to its port after RD_LAT cycles.
module monster_rom_arbiter
  import monster_rom_pkg::*;
#(
  parameter int unsigned ADDR_W   = ROM_ADDR_W,
  parameter int unsigned DATA_W   = PIX_W,
  parameter int unsigned DEPTH    = MONSTER_DEPTH,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              i_clk2,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic [ADDR_W-1:0] i_addr0,
  output logic              o_gnt0,
  output logic              o_rvalid0,
  output logic              o_rerr0,
  input  logic              i_req1,
  input  logic [ADDR_W-1:0] i_addr1,
  output logic              o_gnt1,
  output logic              o_rvalid1,
  output logic              o_rerr1,
  output logic [DATA_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data
);

  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;
  logic             force1;
  rd_tag_t          tag_push;
  rd_tag_t          tag_ret;

  // Grant selection; reset holds every grant low.
  always_comb begin
    o_gnt0     = 1'b0;
    o_gnt1     = 1'b0;
    o_rom_addr = '0;
    force1     = i_req1 && (wait_cnt == CNT_W'(MAX_WAIT));
    if (i_rst_n) begin
      if (force1) begin
        o_gnt1     = 1'b1;
        o_rom_addr = i_addr1;
      end else if (i_req0) begin
        o_gnt0     = 1'b1;
        o_rom_addr = i_addr0;
      end else if (i_req1) begin
        o_gnt1     = 1'b1;
        o_rom_addr = i_addr1;
      end
    end
  end

  // Tag for this cycle's grant; idle cycles push an invalid tag.
  always_comb begin
    tag_push      = '0;
    tag_push.vld  = o_gnt0 | o_gnt1;
    tag_push.port = o_gnt1;
    tag_push.oor  = (o_gnt0 | o_gnt1) && (32'(o_rom_addr) >= DEPTH);
  end

  // Port 1 blocked-cycle counter, saturating at MAX_WAIT.
  always_comb begin
    wait_cnt_nxt = wait_cnt;
    if (!i_req1 || o_gnt1) begin
      wait_cnt_nxt = '0;
    end else if (wait_cnt != CNT_W'(MAX_WAIT)) begin
      wait_cnt_nxt = wait_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk2 or negedge i_rst_n) begin
    if (!i_rst_n) wait_cnt <= '0;
    else          wait_cnt <= wait_cnt_nxt;
  end

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk     (i_clk2),
    .rst_n   (i_rst_n),
    .tag_in  (tag_push),
    .tag_out (tag_ret)
  );

  // Return path: out-of-range reads come back as zero with the error flag.
  assign o_rvalid0 = tag_ret.vld & ~tag_ret.port;
  assign o_rvalid1 = tag_ret.vld &  tag_ret.port;
  assign o_rerr0   = o_rvalid0 & tag_ret.oor;
  assign o_rerr1   = o_rvalid1 & tag_ret.oor;
  assign o_rdata   = (tag_ret.vld && !tag_ret.oor) ? i_rom_data : '0;

  a_x_addr0 : assert property (@(posedge i_clk2) disable iff (!i_rst_n)
    i_req0 |-> !$isunknown(i_addr0));
  a_x_addr1 : assert property (@(posedge i_clk2) disable iff (!i_rst_n)
    i_req1 |-> !$isunknown(i_addr1));
  a_one_gnt : assert property (@(posedge i_clk2) !(o_gnt0 && o_gnt1));

endmodule

// File: tb/tb_monster_rom_arbiter.sv
// Directed bench for monster_rom_arbiter: RD_LAT=1 instance plus an RD_LAT=3 instance.
module tb_monster_rom_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, gnt0, gnt1, rv0, rv1, re0, re1;
  logic [9:0] addr0, addr1, rom_addr;
  logic [7:0] rdata, rom_data;

  logic       req0_3, req1_3, gnt0_3, gnt1_3, rv0_3, rv1_3, re0_3, re1_3;
  logic [9:0] addr0_3, addr1_3, rom_addr_3;
  logic [7:0] rdata_3, rom_data_3;
  logic [7:0] pipe3 [3];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_f(input logic [9:0] a);
    logic [31:0] v;
    v = 32'(a) * 32'd37 + 32'd11;
    return v[7:0] ^ 8'(a >> 3);
  endfunction

  monster_rom_arbiter #(.RD_LAT(1)) u_dut (
    .i_clk2(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_addr0(addr0), .o_gnt0(gnt0), .o_rvalid0(rv0), .o_rerr0(re0),
    .i_req1(req1), .i_addr1(addr1), .o_gnt1(gnt1), .o_rvalid1(rv1), .o_rerr1(re1),
    .o_rdata(rdata), .o_rom_addr(rom_addr), .i_rom_data(rom_data)
  );

  monster_rom_arbiter #(.RD_LAT(3)) u_dut3 (
    .i_clk2(clk), .i_rst_n(rst_n),
    .i_req0(req0_3), .i_addr0(addr0_3), .o_gnt0(gnt0_3), .o_rvalid0(rv0_3), .o_rerr0(re0_3),
    .i_req1(req1_3), .i_addr1(addr1_3), .o_gnt1(gnt1_3), .o_rvalid1(rv1_3), .o_rerr1(re1_3),
    .o_rdata(rdata_3), .o_rom_addr(rom_addr_3), .i_rom_data(rom_data_3)
  );

  // ROM models: data valid RD_LAT cycles after the address is sampled.
  always @(posedge clk) rom_data <= mem_f(rom_addr);
  always @(posedge clk) begin
    pipe3[0] <= mem_f(rom_addr_3);
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign rom_data_3 = pipe3[2];

  typedef struct {
    logic       r0;
    logic [9:0] a0;
    logic       r1;
    logic [9:0] a1;
    logic       g0, g1;
    logic [9:0] ra;
    logic       v0, v1, e0, e1;
    logic [7:0] d;
  } vec_t;

  vec_t tv [12];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input int idx, input logic g0, input logic g1,
                         input logic [9:0] ra, input logic v0, input logic v1,
                         input logic e0, input logic e1, input logic [7:0] d);
    chk({nm, ".gnt0"}, idx, 32'(gnt0), 32'(g0));
    chk({nm, ".gnt1"}, idx, 32'(gnt1), 32'(g1));
    chk({nm, ".rom_addr"}, idx, 32'(rom_addr), 32'(ra));
    chk({nm, ".rvalid0"}, idx, 32'(rv0), 32'(v0));
    chk({nm, ".rvalid1"}, idx, 32'(rv1), 32'(v1));
    chk({nm, ".rerr0"}, idx, 32'(re0), 32'(e0));
    chk({nm, ".rerr1"}, idx, 32'(re1), 32'(e1));
    chk({nm, ".rdata"}, idx, 32'(rdata), 32'(d));
  endtask

  task automatic drive(input logic r0, input logic [9:0] a0, input logic r1, input logic [9:0] a1);
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 10'd5, 1'b0, 10'd0);
    req0_3 = 1'b0; addr0_3 = '0; req1_3 = 1'b0; addr1_3 = '0;

    // Vector table: port 0 stream, port 1 in/out of range, port 0 out of range.
    tv[0]  = '{1'b1, 10'd0,    1'b0, 10'd0,   1'b1, 1'b0, 10'd0,    1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[1]  = '{1'b1, 10'd1,    1'b0, 10'd0,   1'b1, 1'b0, 10'd1,    1'b1, 1'b0, 1'b0, 1'b0, mem_f(10'd0)};
    tv[2]  = '{1'b1, 10'd2,    1'b0, 10'd0,   1'b1, 1'b0, 10'd2,    1'b1, 1'b0, 1'b0, 1'b0, mem_f(10'd1)};
    tv[3]  = '{1'b0, 10'd0,    1'b0, 10'd0,   1'b0, 1'b0, 10'd0,    1'b1, 1'b0, 1'b0, 1'b0, mem_f(10'd2)};
    tv[4]  = '{1'b0, 10'd0,    1'b0, 10'd0,   1'b0, 1'b0, 10'd0,    1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[5]  = '{1'b0, 10'd0,    1'b1, 10'd961, 1'b0, 1'b1, 10'd961,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[6]  = '{1'b0, 10'd0,    1'b1, 10'd962, 1'b0, 1'b1, 10'd962,  1'b0, 1'b1, 1'b0, 1'b0, mem_f(10'd961)};
    tv[7]  = '{1'b0, 10'd0,    1'b0, 10'd0,   1'b0, 1'b0, 10'd0,    1'b0, 1'b1, 1'b0, 1'b1, 8'h00};
    tv[8]  = '{1'b1, 10'd1000, 1'b1, 10'd5,   1'b1, 1'b0, 10'd1000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    tv[9]  = '{1'b0, 10'd0,    1'b1, 10'd5,   1'b0, 1'b1, 10'd5,    1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    tv[10] = '{1'b0, 10'd0,    1'b0, 10'd0,   1'b0, 1'b0, 10'd0,    1'b0, 1'b1, 1'b0, 1'b0, mem_f(10'd5)};
    tv[11] = '{1'b0, 10'd0,    1'b0, 10'd0,   1'b0, 1'b0, 10'd0,    1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

    // Reset state, with a request pending to show grants are held low.
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk_out("reset", 0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("reset.gnt0_3", 0, 32'(gnt0_3), 32'd0);
    chk("reset.rvalid0_3", 0, 32'(rv0_3), 32'd0);
    next_cycle();
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tv[i].r0, tv[i].a0, tv[i].r1, tv[i].a1);
      @(negedge clk);
      chk_out("vec", i, tv[i].g0, tv[i].g1, tv[i].ra, tv[i].v0, tv[i].v1, tv[i].e0, tv[i].e1, tv[i].d);
      next_cycle();
    end

    // Both ports requesting continuously: port 1 forced every 16th cycle.
    for (int k = 0; k < 48; k++) begin
      logic eg1, ev1, ev0;
      drive(1'b1, 10'd10, 1'b1, 10'd20);
      eg1 = ((k % 16) == 15);
      ev1 = (k > 0) && ((k % 16) == 0);
      ev0 = (k > 0) && !ev1;
      @(negedge clk);
      chk_out("starve", k, !eg1, eg1, eg1 ? 10'd20 : 10'd10, ev0, ev1, 1'b0, 1'b0,
              ev1 ? mem_f(10'd20) : (ev0 ? mem_f(10'd10) : 8'h00));
      next_cycle();
    end
    drive(1'b0, 10'd0, 1'b0, 10'd0);
    @(negedge clk);
    chk_out("starve_tail", 0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, mem_f(10'd20));
    next_cycle();

    // Port 1 drops its request at wait_cnt=10: counter restarts from zero.
    for (int k = 0; k < 27; k++) begin
      drive(1'b1, 10'd30, (k != 10), 10'd40);
      @(negedge clk);
      chk("drop.gnt1", k, 32'(gnt1), 32'(k == 26));
      chk("drop.gnt0", k, 32'(gnt0), 32'(k != 26));
      next_cycle();
    end
    drive(1'b0, 10'd0, 1'b0, 10'd0);
    next_cycle();

    // Reset pulse with one read in flight.
    drive(1'b1, 10'd7, 1'b0, 10'd0);
    @(negedge clk);
    chk("rstp.gnt0_pre", 0, 32'(gnt0), 32'd1);
    next_cycle();
    rst_n = 1'b0;
    drive(1'b1, 10'd8, 1'b0, 10'd0);
    @(negedge clk);
    chk_out("rstp_low", 0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    next_cycle();
    rst_n = 1'b1;
    drive(1'b0, 10'd0, 1'b0, 10'd0);
    @(negedge clk);
    chk_out("rstp_rel", 0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    next_cycle();
    drive(1'b1, 10'd3, 1'b0, 10'd0);
    @(negedge clk);
    chk_out("rstp_new", 0, 1'b1, 1'b0, 10'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    next_cycle();
    drive(1'b0, 10'd0, 1'b0, 10'd0);
    @(negedge clk);
    chk_out("rstp_new", 1, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, mem_f(10'd3));
    next_cycle();

    // RD_LAT=3 instance: grants 0,1,0 return three cycles later, in order.
    for (int k = 0; k < 7; k++) begin
      logic [7:0] ed;
      req0_3  = (k == 0) || (k == 2);
      addr0_3 = (k == 0) ? 10'd100 : ((k == 2) ? 10'd300 : 10'd0);
      req1_3  = (k == 1);
      addr1_3 = (k == 1) ? 10'd200 : 10'd0;
      ed = (k == 3) ? mem_f(10'd100) : (k == 4) ? mem_f(10'd200) : (k == 5) ? mem_f(10'd300) : 8'h00;
      @(negedge clk);
      chk("lat3.gnt0", k, 32'(gnt0_3), 32'((k == 0) || (k == 2)));
      chk("lat3.gnt1", k, 32'(gnt1_3), 32'(k == 1));
      chk("lat3.rvalid0", k, 32'(rv0_3), 32'((k == 3) || (k == 5)));
      chk("lat3.rvalid1", k, 32'(rv1_3), 32'(k == 4));
      chk("lat3.rdata", k, 32'(rdata_3), 32'(ed));
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
